// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB command scheduler: FSM encoding,
// device ID default, soft-reset register decode and the delay-length helper.
package sccb_pkg;

  typedef enum logic [3:0] {
    RST_HOLD,
    PWRUP,
    INIT_ISSUE,
    INIT_WAIT,
    INIT_GAP,
    IDLE,
    USR_ISSUE,
    USR_WAIT,
    USR_GAP
  } sccb_state_e;

  localparam logic [7:0] SCCB_ID_DEF = 8'h60;
  localparam logic [7:0] REG_COM7    = 8'h12;
  localparam int         COM7_SRST   = 7;
  localparam logic [7:0] REG_BANK    = 8'hFF;
  localparam int         CNT_W       = 20;

  // A state lasting N cycles loads N-1; N=0 behaves as N=1.
  function automatic logic [CNT_W-1:0] cnt_len(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/sccb_delay_cnt.sv
// Loadable down-counter shared by the reset-hold, power-up and gap states.
// It stops at zero; zero is asserted while the count is 0.
module sccb_delay_cnt
  import sccb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= len;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sccb_sched.sv
// SCCB command scheduler: sensor reset and power-up, init-table walk, then
// single runtime writes granted to one user requester.
module sccb_sched
  import sccb_pkg::*;
#(
  parameter int               NUM_INS      = 192,
  parameter logic [7:0]       SCCB_ID      = SCCB_ID_DEF,
  parameter logic [CNT_W-1:0] RESET_HOLD   = 20'd1000,
  parameter logic [CNT_W-1:0] PWRUP_CYCLES = 20'd50000,
  parameter logic [CNT_W-1:0] GAP_CYCLES   = 20'd500
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        usr_req,
  input  logic [15:0] usr_data,
  output logic        usr_gnt,
  output logic        sccb_start,
  output logic [7:0]  sccb_id,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_busy,
  output logic        rstsccb,
  output logic        init_done,
  output sccb_state_e dbg_state
);

  // usr_req/usr_gnt handshake: the requester raises usr_req with usr_data
  // stable and holds both until usr_gnt; the cycle with usr_req && usr_gnt is
  // the single transfer cycle. usr_gnt is only offered in IDLE.

  localparam logic [7:0] LAST_IDX = 8'(NUM_INS - 1);

  sccb_state_e      state_q, state_d;
  logic             armed_q, armed_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_zero, soft_rst;
  logic [CNT_W-1:0] cnt_len_v, gap_len;

  sccb_delay_cnt u_delay (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .len   (cnt_len_v),
    .zero  (cnt_zero)
  );

  // A COM7 write with the soft-reset bit needs a full power-up wait after it.
  assign soft_rst = (addr_q == REG_COM7) && wdata_q[COM7_SRST];
  assign gap_len  = soft_rst ? cnt_len(PWRUP_CYCLES) : cnt_len(GAP_CYCLES);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    cnt_load   = 1'b0;
    cnt_len_v  = gap_len;
    usr_gnt    = 1'b0;
    sccb_start = 1'b0;
    case (state_q)
      RST_HOLD: begin
        // The counter is 0 out of reset, so the first hold cycle arms it.
        if (!armed_q && RESET_HOLD > 20'd1) begin
          cnt_load  = 1'b1;
          cnt_len_v = RESET_HOLD - 20'd2;
        end else if (!armed_q || cnt_zero) begin
          state_d   = PWRUP;
          cnt_load  = 1'b1;
          cnt_len_v = cnt_len(PWRUP_CYCLES);
        end
      end
      PWRUP: if (cnt_zero) state_d = INIT_ISSUE;
      INIT_ISSUE: begin
        sccb_start = 1'b1;
        addr_d     = rom_data[15:8];
        wdata_d    = rom_data[7:0];
        state_d    = INIT_WAIT;
      end
      INIT_WAIT: if (armed_q && !sccb_busy) begin
        state_d  = INIT_GAP;
        cnt_load = 1'b1;
      end
      INIT_GAP: if (cnt_zero) begin
        if (rom_addr_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rom_addr_d = rom_addr_q + 8'd1;
          state_d    = INIT_ISSUE;
        end
      end
      IDLE: if (usr_req) begin
        usr_gnt = 1'b1;
        addr_d  = usr_data[15:8];
        wdata_d = usr_data[7:0];
        state_d = USR_ISSUE;
      end
      USR_ISSUE: begin
        sccb_start = 1'b1;
        state_d    = USR_WAIT;
      end
      USR_WAIT: if (armed_q && !sccb_busy) begin
        state_d  = USR_GAP;
        cnt_load = 1'b1;
      end
      USR_GAP: if (cnt_zero) state_d = IDLE;
      default: state_d = RST_HOLD;
    endcase
    armed_d = (state_d == state_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RST_HOLD;
      armed_q    <= 1'b0;
      rom_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      rom_addr_q <= rom_addr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  // During INIT_ISSUE the ROM word is shown directly so the engine sees it
  // together with sccb_start; afterwards the latched copy holds it.
  assign sccb_addr  = (state_q == INIT_ISSUE) ? rom_data[15:8] : addr_q;
  assign sccb_wdata = (state_q == INIT_ISSUE) ? rom_data[7:0]  : wdata_q;
  assign sccb_id    = SCCB_ID;
  assign rom_addr   = rom_addr_q;
  assign rstsccb    = (state_q != RST_HOLD);
  assign init_done  = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sccb_sched.sv
// Self-checking bench for sccb_sched: ROM table and busy-for-5 engine model,
// scoreboard of expected {reg,val} writes popped on each sccb_start.
module tb_sccb_sched;
  import sccb_pkg::*;

  localparam int NUM_INS    = 4;
  localparam int RESET_HOLD = 4;
  localparam int PWRUP      = 8;
  localparam int GAP        = 3;
  localparam int BUSY_LEN   = 5;
  localparam int PERIOD     = 1 + BUSY_LEN + 1 + GAP;
  localparam int PERIOD_SR  = 1 + BUSY_LEN + 1 + PWRUP;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        usr_req;
  logic [15:0] usr_data;
  logic        usr_gnt;
  logic        sccb_start;
  logic [7:0]  sccb_id;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_busy;
  logic        rstsccb;
  logic        init_done;
  sccb_state_e dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  sccb_sched #(
    .NUM_INS      (NUM_INS),
    .SCCB_ID      (8'h60),
    .RESET_HOLD   (20'(RESET_HOLD)),
    .PWRUP_CYCLES (20'(PWRUP)),
    .GAP_CYCLES   (20'(GAP))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .usr_req    (usr_req),
    .usr_data   (usr_data),
    .usr_gnt    (usr_gnt),
    .sccb_start (sccb_start),
    .sccb_id    (sccb_id),
    .sccb_addr  (sccb_addr),
    .sccb_wdata (sccb_wdata),
    .sccb_busy  (sccb_busy),
    .rstsccb    (rstsccb),
    .init_done  (init_done),
    .dbg_state  (dbg_state)
  );

  // init-table ROM and engine model
  logic [15:0] rom_tbl [NUM_INS];
  assign rom_data = rom_tbl[rom_addr[1:0]];

  int bcnt;
  always @(posedge clk) begin
    if (!reset)          bcnt <= 0;
    else if (sccb_start) bcnt <= BUSY_LEN;
    else if (bcnt > 0)   bcnt <= bcnt - 1;
  end
  assign sccb_busy = (bcnt != 0);

  // scoreboard state
  logic [15:0] exp_q[$];
  int start_cyc[$];
  int gnt_cyc[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cyc = -1;
  bit done_seen = 0;
  int early_gnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int at_s(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1000;
  endfunction

  function automatic int at_g(input int i);
    return (i < gnt_cyc.size()) ? gnt_cyc[i] : -1000;
  endfunction

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (sccb_start) begin
      start_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("start_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sccb_write", {16'h0, sccb_addr, sccb_wdata}, {16'h0, e});
      end
    end
    if (usr_gnt) begin
      gnt_cyc.push_back(cyc);
      if (!init_done) early_gnt++;
    end
    if (init_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  // driver tasks
  task automatic push_table();
    for (int i = 0; i < NUM_INS; i++) exp_q.push_back(rom_tbl[i]);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("init_done_seen", {31'h0, init_done}, 32'd1);
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = usr_gnt;
    end
    check(tag, {31'h0, seen}, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    reset    = 1'b0;
    usr_req  = 1'b0;
    usr_data = 16'h0;
    rom_tbl  = '{16'hFF01, 16'h1280, 16'hFF00, 16'h2CFF};
    push_table();
    // user request held from reset; must wait for init to finish
    usr_req  = 1'b1;
    usr_data = 16'h5566;
    exp_q.push_back(16'h5566);

    repeat (3) @(negedge clk);
    check("rst_rstsccb",  {31'h0, rstsccb},    32'd0);
    check("rst_start",    {31'h0, sccb_start}, 32'd0);
    check("rst_addr",     {24'h0, sccb_addr},  32'd0);
    check("rst_wdata",    {24'h0, sccb_wdata}, 32'd0);
    check("rst_rom_addr", {24'h0, rom_addr},   32'd0);
    check("rst_gnt",      {31'h0, usr_gnt},    32'd0);
    check("rst_done",     {31'h0, init_done},  32'd0);
    check("sccb_id",      {24'h0, sccb_id},    32'h60);

    reset = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rstsccb && n < 50);
    check("rst_hold_len", 32'(n), 32'(RESET_HOLD));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sccb_start && n < 50);
    check("pwrup_len", 32'(n), 32'(PWRUP));

    wait_done(600);
    @(posedge clk); #1;
    usr_req = 1'b0;
    repeat (15) @(negedge clk);
    check("starts_after_init", 32'(start_cyc.size()), 32'd5);
    check("gap_ff01",  32'(at_s(1) - at_s(0)), 32'(PERIOD));
    check("gap_soft",  32'(at_s(2) - at_s(1)), 32'(PERIOD_SR));
    check("gap_ff00",  32'(at_s(3) - at_s(2)), 32'(PERIOD));
    check("done_rise", 32'(done_cyc - at_s(3)), 32'(PERIOD));
    check("early_gnt", 32'(early_gnt), 32'd0);
    check("gnt_count", 32'(gnt_cyc.size()), 32'd1);
    check("gnt_at_done", 32'(at_g(0) - done_cyc), 32'd0);
    check("usr_start_lat", 32'(at_s(4) - done_cyc), 32'd1);

    // back-to-back user requests
    @(posedge clk); #1;
    usr_req  = 1'b1;
    usr_data = 16'h1111;
    exp_q.push_back(16'h1111);
    wait_gnt("gnt1_seen");
    @(posedge clk); #1;
    usr_data = 16'h2222;
    exp_q.push_back(16'h2222);
    wait_gnt("gnt2_seen");
    @(posedge clk); #1;
    usr_req = 1'b0;
    repeat (15) @(negedge clk);
    check("gnt_total", 32'(gnt_cyc.size()), 32'd3);
    check("usr1_start_lat", 32'(at_s(5) - at_g(1)), 32'd1);
    check("gnt2_after_gap", 32'(at_g(2) - at_s(5)), 32'(PERIOD));
    check("usr2_start_lat", 32'(at_s(6) - at_g(2)), 32'd1);
    check("done_sticky", {31'h0, init_done}, 32'd1);
    check("rom_addr_hold", {24'h0, rom_addr}, 32'(NUM_INS - 1));
    check("exp_q_empty1", 32'(exp_q.size()), 32'd0);

    // full reset, then a one-cycle reset during the third write's wait
    reset = 1'b0;
    exp_q.delete();
    start_cyc.delete();
    gnt_cyc.delete();
    done_seen = 0;
    @(negedge clk);
    check("rst2_done",    {31'h0, init_done}, 32'd0);
    check("rst2_rstsccb", {31'h0, rstsccb},   32'd0);
    reset = 1'b1;
    push_table();
    k = 0;
    n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (sccb_start) k++;
    end
    check("third_start_seen", 32'(k), 32'd3);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rstsccb",  {31'h0, rstsccb},    32'd0);
    check("mid_done",     {31'h0, init_done},  32'd0);
    check("mid_rom_addr", {24'h0, rom_addr},   32'd0);
    check("mid_start",    {31'h0, sccb_start}, 32'd0);
    exp_q.delete();
    start_cyc.delete();
    push_table();
    wait_done(600);
    repeat (3) @(negedge clk);
    check("reinit_starts", 32'(start_cyc.size()), 32'd4);
    check("reinit_soft_gap", 32'(at_s(2) - at_s(1)), 32'(PERIOD_SR));
    check("exp_q_empty2", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
